// File: rtl/full_subtractor_core.sv
// Registered ripple-borrow full subtractor: {Bout, Difference} = {0,A} - {0,B} - Bin.
// The borrow chain is built from WIDTH explicit one-bit cells. The result is
// registered one clock after a valid input.
// Optional feature: define FULL_SUB_OVF_EN to add a registered two's-complement
// overflow flag (Ovf).

// One bit of the borrow chain: difference bit and borrow to the next bit.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module full_subtractor_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Difference,
`ifdef FULL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Bout
);
    // brw[i] is the borrow into bit i; brw[WIDTH] is the final borrow out
    logic [WIDTH:0]   brw;
    logic [WIDTH-1:0] dif;

    assign brw[0] = Bin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            full_subtractor_cell u_cell (
                .a  (A[i]),
                .b  (B[i]),
                .bi (brw[i]),
                .d  (dif[i]),
                .bo (brw[i+1])
            );
        end
    endgenerate

    // Result register: reset clears, valid captures, idle holds the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            Difference <= '0;
            Bout       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Difference <= dif;
                Bout       <= brw[WIDTH];
            end
        end
    end

`ifdef FULL_SUB_OVF_EN
    // Signed overflow: borrow into the sign bit differs from borrow out of it
    always_ff @(posedge clk) begin
        if (rst)
            Ovf <= 1'b0;
        else if (in_valid)
            Ovf <= brw[WIDTH] ^ brw[WIDTH-1];
    end
`endif

endmodule

// File: tb/tb_full_subtractor_core.sv
// Bench for full_subtractor_core: a 1-bit and an 8-bit instance share clock and
// reset. Stimulus pushes expected results from an arithmetic model into a queue
// per instance; a monitor pops and compares when outputs are presented, and
// also checks that idle cycles hold the last result.
module tb_full_subtractor_core;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       v8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov1, d1, bo1, ov8, bo8;
    logic [7:0] d8;
    logic       ovf1, ovf8;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q8[$];
    exp_t h1, h8;

    always #5 clk = ~clk;

`ifdef FULL_SUB_OVF_EN
    full_subtractor_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Bin(bin1),
        .out_valid(ov1), .Difference(d1), .Ovf(ovf1), .Bout(bo1));
    full_subtractor_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Bin(bin8),
        .out_valid(ov8), .Difference(d8), .Ovf(ovf8), .Bout(bo8));
`else
    full_subtractor_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Bin(bin1),
        .out_valid(ov1), .Difference(d1), .Bout(bo1));
    full_subtractor_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Bin(bin8),
        .out_valid(ov8), .Difference(d8), .Bout(bo8));
    assign ovf1 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    // Reference: plain integer arithmetic on unsigned and signed readings
    function automatic exp_t model(input int w, input longint a, input longint b, input longint bi);
        exp_t   e;
        longint mask, half, diff, sa, sb, sr;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        diff  = a - b - bi;
        e.d   = 8'(diff & mask);
        e.bo  = (diff < 0);
        sa    = (a >= half) ? a - (longint'(1) << w) : a;
        sb    = (b >= half) ? b - (longint'(1) << w) : b;
        sr    = sa - sb - bi;
        e.ovf = (sr < -half) || (sr > half - 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; queue expected results
    task automatic step(input logic r,
                        input logic vv1, input logic aa1, input logic bb1, input logic bi1,
                        input logic vv8, input logic [7:0] aa8, input logic [7:0] bb8, input logic bi8);
        @(negedge clk);
        rst = r;
        v1 = vv1; a1 = aa1; b1 = bb1; bin1 = bi1;
        v8 = vv8; a8 = aa8; b8 = bb8; bin8 = bi8;
        if (!r && vv1) q1.push_back(model(1, longint'(aa1), longint'(bb1), longint'(bi1)));
        if (!r && vv8) q8.push_back(model(8, longint'(aa8), longint'(bb8), longint'(bi8)));
    endtask

    task automatic idle8(input logic r);
        step(r, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
             1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic go8(input logic r, input logic [7:0] aa, input logic [7:0] bb, input logic bi);
        step(r, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, aa, bb, bi);
    endtask

    // Monitor: checks every result slot just after the rising edge
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            h1 = '{d: 8'h0, bo: 1'b0, ovf: 1'b0};
            h8 = '{d: 8'h0, bo: 1'b0, ovf: 1'b0};
            chk("rst_valid1", 64'(ov1), 64'(0));
            chk("rst_valid8", 64'(ov8), 64'(0));
        end else begin
            chk("valid1", 64'(ov1), 64'(q1.size() != 0));
            chk("valid8", 64'(ov8), 64'(q8.size() != 0));
            if (q1.size() != 0) h1 = q1.pop_front();
            if (q8.size() != 0) h8 = q8.pop_front();
        end
        chk("diff1", 64'(d1), 64'(h1.d[0]));
        chk("bout1", 64'(bo1), 64'(h1.bo));
        chk("diff8", 64'(d8), 64'(h8.d));
        chk("bout8", 64'(bo8), 64'(h8.bo));
`ifdef FULL_SUB_OVF_EN
        chk("ovf1", 64'(ovf1), 64'(h1.ovf));
        chk("ovf8", 64'(ovf8), 64'(h8.ovf));
`endif
    end

    initial begin
        logic [15:0] tbl;
        logic [7:0]  r8;
        tbl = 16'b00_11_11_01_10_00_00_11;

        // Reset held two cycles with a valid input present
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        @(posedge clk); #3;
        chk("reset_valid", 64'(ov8), 64'(0));
        chk("reset_diff", 64'(d8), 64'(0));
        chk("reset_bout", 64'(bo8), 64'(0));

        // 1-bit truth table, (A,B,Bin) = 000..111
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'(i >> 2), 1'(i >> 1), 1'(i),
                 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #3;
            chk("tt_diff", 64'(d1), 64'(tbl[15-2*i]));
            chk("tt_bout", 64'(bo1), 64'(tbl[14-2*i]));
        end

        // 8-bit wrap and ordinary subtraction
        go8(1'b0, 8'h00, 8'hFF, 1'b1);
        @(posedge clk); #3;
        chk("wrap_diff", 64'(d8), 64'(8'h00));
        chk("wrap_bout", 64'(bo8), 64'(1));
        go8(1'b0, 8'h50, 8'h30, 1'b0);
        @(posedge clk); #3;
        chk("plain_diff", 64'(d8), 64'(8'h20));
        chk("plain_bout", 64'(bo8), 64'(0));

        // Equal operands with and without borrow in
        r8 = 8'($urandom);
        go8(1'b0, r8, r8, 1'b0);
        @(posedge clk); #3;
        chk("eq_diff", 64'(d8), 64'(8'h00));
        chk("eq_bout", 64'(bo8), 64'(0));
        go8(1'b0, r8, r8, 1'b1);
        @(posedge clk); #3;
        chk("eqb_diff", 64'(d8), 64'(8'hFF));
        chk("eqb_bout", 64'(bo8), 64'(1));

        // Idle hold: one pulse, then three idle cycles with changing inputs
        go8(1'b0, 8'h05, 8'h03, 1'b1);
        repeat (3) idle8(1'b0);
        @(posedge clk); #3;
        chk("hold_valid", 64'(ov8), 64'(0));
        chk("hold_diff", 64'(d8), 64'(8'h01));
        chk("hold_bout", 64'(bo8), 64'(0));

        // Back-to-back with reset on the third valid cycle
        go8(1'b0, 8'h09, 8'h02, 1'b0);
        go8(1'b0, 8'h02, 8'h09, 1'b0);
        go8(1'b1, 8'h33, 8'h11, 1'b0);
        @(posedge clk); #3;
        chk("coll_valid", 64'(ov8), 64'(0));
        chk("coll_diff", 64'(d8), 64'(0));
        idle8(1'b0);

`ifdef FULL_SUB_OVF_EN
        go8(1'b0, 8'h80, 8'h01, 1'b0);
        @(posedge clk); #3;
        chk("ovf_diff", 64'(d8), 64'(8'h7F));
        chk("ovf_set", 64'(ovf8), 64'(1));
        chk("ovf_bout", 64'(bo8), 64'(0));
        go8(1'b0, 8'h10, 8'h01, 1'b0);
        @(posedge clk); #3;
        chk("ovf_clr", 64'(ovf8), 64'(0));
`endif

        // Random traffic on both instances with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 24) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle8(1'b0);
        idle8(1'b0);
        @(negedge clk);
        chk("drain1", 64'(q1.size()), 64'(0));
        chk("drain8", 64'(q8.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
